// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - sequenced ALU control decoder with per-class execution latency
//
// Accepts one decoded instruction per in_valid/in_ready handshake, latches the
// 4-bit ALU control code and illegal flag, then holds out_valid low until the
// op's latency class has elapsed. The result stays on the outputs until the
// consumer takes it with out_ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, highest priority
//   flush        synchronous abort of the in-flight op; blocks acceptance
//   in_valid     request valid
//   in_ready     block can accept a request this cycle
//   alu_op       main-decoder ALU op class
//   funct        instruction funct field
//   fp_operation selects the FP decode table
//   out_valid    alu_control/illegal valid
//   out_ready    consumer takes the result this cycle
//   alu_control  registered ALU control code
//   illegal      funct not recognised in the selected table
//   busy         state != IDLE

module alu_exec_ctrl #(
  parameter int FP_ADD_LAT   = 3,
  parameter int FP_MUL_LAT   = 4,
  parameter bit SUB_S_NATIVE = 1'b1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic       fp_operation,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ADD_LAT = CNT_W'(FP_ADD_LAT);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(FP_MUL_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic [CNT_W-1:0] dec_lat;
  logic             accept;

  // Decode tables. The latency class follows the instruction, not the code:
  // in legacy mode SUB.S shares ADD.S's code but still needs the FP add latency.
  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_illegal = 1'b0;
    dec_lat     = ONE;
    if (fp_operation) begin
      case (funct)
        6'b000000: begin
          dec_ctrl = 4'b1101;
          dec_lat  = ADD_LAT;
        end
        6'b000001: begin
          dec_ctrl = SUB_S_NATIVE ? 4'b0100 : 4'b1101;
          dec_lat  = ADD_LAT;
        end
        6'b000010: begin
          dec_ctrl = 4'b1100;
          dec_lat  = MUL_LAT;
        end
        6'b000100: dec_ctrl = 4'b1110;
        6'b000110: dec_ctrl = 4'b1111;
        default:   dec_illegal = 1'b1;
      endcase
    end else begin
      case (alu_op)
        2'b00: dec_ctrl = 4'b0010;
        2'b01: dec_ctrl = 4'b0110;
        2'b10: begin
          case (funct)
            6'b100000: dec_ctrl = 4'b0010;
            6'b100010: dec_ctrl = 4'b0110;
            6'b100100: dec_ctrl = 4'b0000;
            6'b100101: dec_ctrl = 4'b0001;
            6'b101010: dec_ctrl = 4'b0111;
            6'b000000: dec_ctrl = 4'b1000;
            6'b000010: dec_ctrl = 4'b1001;
            6'b100110: dec_ctrl = 4'b1010;
            6'b100111: dec_ctrl = 4'b1011;
            default:   dec_illegal = 1'b1;
          endcase
        end
        default: begin
          // Immediate-class ops: anything unrecognised falls back to add.
          case (funct[5:3])
            3'b001:  dec_ctrl = 4'b0000;
            3'b010:  dec_ctrl = 4'b0001;
            3'b011:  dec_ctrl = 4'b1010;
            default: dec_ctrl = 4'b0010;
          endcase
        end
      endcase
    end
  end

  // Ready also in DONE when the consumer drains this cycle, which lets
  // single-cycle ops stream back-to-back without a bubble.
  assign in_ready = !reset && !flush &&
                    ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_control <= 4'b0000;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      // The latched code is kept; only the op's progress is discarded.
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      alu_control <= dec_ctrl;
      illegal     <= dec_illegal;
      cnt         <= dec_lat - ONE;
      busy        <= 1'b1;
      if (dec_lat == ONE) begin
        state     <= DONE;
        out_valid <= 1'b1;
      end else begin
        state     <= EXEC;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        EXEC: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        IDLE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
